// File: rtl/alu_exec32.sv
// alu_exec32 -- execution unit for the RV32 one-hot ALU op code.
//
// Accepts op/a/b over a valid/ready handshake. Add, sub, logic and compare
// ops finish in one cycle. Shifts go through an iterative shifter that moves
// one bit per cycle. The result is returned over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of the in-flight operation
//   in_valid   op/a/b valid
//   in_ready   unit can accept an op (IDLE only)
//   op         one-hot op: 0 add,1 sub,2 and,3 or,4 xor,5 sll,6 srl,7 sra,8 slt,9 sltu
//   a, b       operands (shift amount is b[4:0])
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     computed value
//   illegal    op was not exactly one-hot (result forced to 0)
module alu_exec32 #(
  parameter int OP_WIDTH = 10,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     result,
  output logic                illegal
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_n;
  logic [XLEN-1:0]       result_q, result_n;
  logic                  illegal_q, illegal_n;
  logic [XLEN-1:0]       work_q, work_n;
  logic [4:0]            cnt_q, cnt_n;
  logic [OP_WIDTH-1:0]   op_q, op_n;

  logic                  op_legal;
  logic                  is_shift;
  logic [4:0]            shamt;
  logic [XLEN-1:0]       alu_res;
  logic [XLEN-1:0]       shift_one;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign op_legal = (op != '0) && ((op & (op - OP_WIDTH'(1))) == '0);
  assign is_shift = |op[7:5];
  assign shamt    = b[4:0];

  always_comb begin
    alu_res = '0;
    if (op[0]) alu_res = a + b;
    if (op[1]) alu_res = a - b;
    if (op[2]) alu_res = a & b;
    if (op[3]) alu_res = a | b;
    if (op[4]) alu_res = a ^ b;
    if (op[8]) alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
    if (op[9]) alu_res = {{(XLEN-1){1'b0}}, (a < b)};
  end

  // One-bit step of the iterative shifter, selected by the latched op.
  always_comb begin
    if (op_q[5])
      shift_one = {work_q[XLEN-2:0], 1'b0};
    else if (op_q[6])
      shift_one = {1'b0, work_q[XLEN-1:1]};
    else
      shift_one = {work_q[XLEN-1], work_q[XLEN-1:1]};
  end

  always_comb begin
    state_n   = state;
    result_n  = result_q;
    illegal_n = illegal_q;
    work_n    = work_q;
    cnt_n     = cnt_q;
    op_n      = op_q;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_n = op;
            if (!op_legal) begin
              result_n  = '0;
              illegal_n = 1'b1;
              state_n   = DONE;
            end else if (is_shift && (shamt != 5'd0)) begin
              work_n    = a;
              cnt_n     = shamt;
              illegal_n = 1'b0;
              state_n   = SHIFT;
            end else begin
              result_n  = is_shift ? a : alu_res;
              illegal_n = 1'b0;
              state_n   = DONE;
            end
          end
        end
        SHIFT: begin
          work_n = shift_one;
          cnt_n  = cnt_q - 5'd1;
          // Last step: the freshly shifted value is the result.
          if (cnt_q == 5'd1) begin
            result_n = shift_one;
            state_n  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      work_q    <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
    end else begin
      state     <= state_n;
      result_q  <= result_n;
      illegal_q <= illegal_n;
      work_q    <= work_n;
      cnt_q     <= cnt_n;
      op_q      <= op_n;
    end
  end

endmodule

// File: tb/tb_alu_exec32.sv
// Testbench for alu_exec32: directed vector table, random ops against a
// behavioural model, and hand-written flush/reset/backpressure sequences.
module tb_alu_exec32;

  localparam logic [9:0] ADD = 10'd1, SUB = 10'd2, AND = 10'd4, OR = 10'd8,
                         XOR = 10'd16, SLL = 10'd32, SRL = 10'd64, SRA = 10'd128,
                         SLT = 10'd256, SLTU = 10'd512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec32 #(.OP_WIDTH(10), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal)
  );

  typedef struct {
    logic [9:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          hold;
  } vec_t;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference model straight from the ISA definitions.
  function automatic void model(input logic [9:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic il, output int lat);
    int sh;
    sh  = int'(y[4:0]);
    il  = 1'b0;
    lat = 1;
    if ($countones(o) != 1) begin
      r  = 0;
      il = 1'b1;
    end else begin
      case (o)
        ADD:  r = x + y;
        SUB:  r = x - y;
        AND:  r = x & y;
        OR:   r = x | y;
        XOR:  r = x ^ y;
        SLL:  r = x << sh;
        SRL:  r = x >> sh;
        SRA:  r = $unsigned($signed(x) >>> sh);
        SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        default: r = (x < y) ? 32'd1 : 32'd0;
      endcase
      if ((o == SLL || o == SRL || o == SRA) && sh != 0) lat = sh + 1;
    end
  endfunction

  task automatic run_op(input string nm, input logic [9:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic ei, input int el, input int hold);
    int guard;
    int lat;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 10'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(el));
    for (int i = 0; i < hold; i++) begin
      check({nm, " hold valid"}, 32'(out_valid), 32'd1);
      check({nm, " hold ready"}, 32'(in_ready), 32'd0);
      check({nm, " hold result"}, result, er);
      @(posedge clk); #1;
    end
    check({nm, " result"}, result, er);
    check({nm, " illegal"}, 32'(illegal), 32'(ei));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, " valid drop"}, 32'(out_valid), 32'd0);
    check({nm, " ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] er;
    logic        ei;
    int          el;
    logic [9:0]  ro;
    logic [31:0] ra, rb;
    int          seen;

    vecs.push_back('{ADD,  32'hFFFF_FFFF, 32'd1,          32'd0,          1'b0, 1,  0});
    vecs.push_back('{SUB,  32'd0,         32'd1,          32'hFFFF_FFFF,  1'b0, 1,  0});
    vecs.push_back('{AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0, 1,  0});
    vecs.push_back('{OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'hFFF0_FFF0,  1'b0, 1,  0});
    vecs.push_back('{XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'hFF00_FF00,  1'b0, 1,  0});
    vecs.push_back('{SLT,  32'h8000_0000, 32'd1,          32'd1,          1'b0, 1,  0});
    vecs.push_back('{SLTU, 32'h8000_0000, 32'd1,          32'd0,          1'b0, 1,  0});
    vecs.push_back('{SLT,  32'd5,         32'd5,          32'd0,          1'b0, 1,  0});
    vecs.push_back('{SLTU, 32'd5,         32'd5,          32'd0,          1'b0, 1,  0});
    vecs.push_back('{SRA,  32'h8000_0000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32, 0});
    vecs.push_back('{SRL,  32'h8000_0000, 32'hFFFF_FFFF,  32'd1,          1'b0, 32, 0});
    vecs.push_back('{SLL,  32'd1,         32'd0,          32'd1,          1'b0, 1,  0});
    vecs.push_back('{SLL,  32'd1,         32'hFFFF_FFE4,  32'd16,         1'b0, 5,  0});
    vecs.push_back('{ADD,  32'd3,         32'd4,          32'd7,          1'b0, 1,  5});
    vecs.push_back('{10'b0000000011, 32'h1234_5678, 32'd9, 32'd0,        1'b1, 1,  0});
    vecs.push_back('{10'd0, 32'h1234_5678, 32'd9,         32'd0,          1'b1, 1,  0});
    vecs.push_back('{ADD,  32'd10,        32'd20,         32'd30,         1'b0, 1,  0});

    // Reset state
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].ill, vecs[i].lat, vecs[i].hold);

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) ro = 10'($urandom_range(0, 1023));
      else ro = 10'(1 << $urandom_range(0, 9));
      ra = $urandom;
      rb = $urandom;
      model(ro, ra, rb, er, ei, el);
      run_op($sformatf("rand%0d", i), ro, ra, rb, er, ei, el, int'($urandom_range(0, 3)));
    end

    // Flush on the third cycle of a 20-step shift
    @(negedge clk);
    in_valid = 1'b1; op = SLL; a = 32'd1; b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", 32'(in_ready), 32'd1);
    check("flush out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    out_ready = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("flush no pulse", 32'(seen), 32'd0);

    // Flush beats acceptance in the same cycle
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = ADD; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (4) begin
      if (out_valid || !in_ready) seen++;
      @(posedge clk); #1;
    end
    check("flush blocks accept", 32'(seen), 32'd0);

    // Reset mid-shift
    @(negedge clk);
    in_valid = 1'b1; op = SRL; a = 32'hFFFF_FFFF; b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst shift out_valid", 32'(out_valid), 32'd0);
    check("rst shift result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while an illegal result waits
    run_op("pre-rst", 10'd0, 32'd1, 32'd1, 32'd0, 1'b1, 1, 0);
    @(negedge clk);
    in_valid = 1'b1; op = 10'd0; a = 32'd7; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst done illegal", 32'(illegal), 32'd0);
    check("rst done out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    out_ready = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("rst no pulse", 32'(seen), 32'd0);
    run_op("post-rst sra", SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec32.md
Name: alu_exec32

Overview:
- Execution-side consumer of the 10-bit one-hot ALU operation code produced by the RV32 arithmetic/logic decode stage.
- Takes the op code and two 32-bit operands through a valid/ready handshake and computes the result.
- Add, sub, logic and compare ops take a single cycle. Shifts use an iterative one-bit-per-cycle shifter to save area.
- Returns the result over a valid/ready output handshake to the writeback path.

Parameters:
- OP_WIDTH, 10, width of the one-hot op code. Bit mapping: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
- XLEN, 32, operand and result width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; discards the in-flight operation.
- in_valid  in  1  op/a/b are valid.
- in_ready  out  1  unit can accept an operation.
- op  in  OP_WIDTH  one-hot ALU op code.
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2 or immediate).
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  computed value.
- illegal  out  1  qualifies result; high when op was not exactly one-hot.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, result=0, illegal=0, shift counter=0, in_ready=1 once released.
- States:
  - IDLE: in_ready=1.
  - SHIFT: iterating.
  - DONE: out_valid=1.
- in_ready is 1 only in IDLE. Transfer occurs when in_valid & in_ready on an edge. op, a and b are captured at that edge; input changes afterwards are ignored.
- IDLE with transfer, non-shift op → result computed and registered, go to DONE. Latency: out_valid high on the cycle after acceptance.
- Single-cycle ops:
  - add: a+b mod 2^32.
  - sub: a-b mod 2^32.
  - and/or/xor: bitwise.
  - slt: {31'b0, $signed(a)<$signed(b)}.
  - sltu: {31'b0, a<b}.
- Shift ops: shamt=b[4:0]; b[31:5] ignored.
  - shamt=0 → result=a, go to DONE (latency 1).
  - shamt>0 → load working reg=a and counter=shamt, go to SHIFT.
- SHIFT: each cycle the working reg shifts by 1 and the counter decrements.
  - sll: fill with 0 from the LSB side.
  - srl: fill with 0 from the MSB side.
  - sra: replicate bit 31.
  - When the counter reaches 0 after the decrement, result=working reg and go to DONE.
  - Total latency from acceptance to out_valid = shamt+1 cycles. shamt=31 gives 32 cycles.
- Illegal op (zero bits set, or more than one bit set): result=0, illegal=1, go to DONE with latency 1. No shift is started. illegal is 0 for all legal ops.
- DONE: result and illegal stay stable while out_valid=1 and out_ready=0. When out_valid & out_ready: out_valid=0 and go to IDLE. in_ready rises in the following cycle (no same-cycle re-accept). Maximum throughput is one op per 2 cycles.
- flush=1 on an edge from any state → IDLE, out_valid=0, counter=0. flush has priority over acceptance and completion in the same cycle. Any input presented with flush is not accepted.
- rst_n asserted mid-SHIFT or mid-DONE aborts immediately. No result is emitted after release.
- Reset values also apply to the working register and the latched op.

Test Plan:
- Single-cycle ops:
  - add a=32'hFFFF_FFFF, b=1: result=0 one cycle after acceptance, illegal=0.
  - sub a=0, b=1: result=32'hFFFF_FFFF.
  - and/or/xor a=32'hF0F0_F0F0, b=32'h0FF0_0FF0: results 32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00.
- Compares with a=32'h8000_0000, b=1:
  - slt: result=1.
  - sltu: result=0.
  - a=b=5: both results 0.
- Shifts:
  - sra a=32'h8000_0000, b=32'hFFFF_FFFF (shamt 31): out_valid exactly 32 cycles after acceptance, result=32'hFFFF_FFFF.
  - srl same operands: result=1.
  - sll a=1, b=0: result=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after add 3+4.
  - result=7 and out_valid stay stable; in_ready=0 throughout.
  - out_ready=1 → out_valid drops next cycle, then in_ready=1.
- Illegal op: op=10'b0000000011 and op=0 each → result=0, illegal=1, latency 1. A following legal add leaves illegal=0.
- Abort:
  - flush at cycle 3 of an sll shamt=20: returns to IDLE, no out_valid pulse.
  - rst_n low mid-shift: outputs zero immediately. After release, the next op completes correctly.
